alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle ALU (the `alu_wrap` datapath, including the iterative MULT) between `NREQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one request at a time, launches the ALU, and waits for completion. It then returns the full-width result to the granted requester on a one-hot response handshake. It sits between the requesting masters and a single `alu_wrap` instance.

---
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle ALU among NREQ requesters.
// Optional WAIT-state watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
  parameter int DWIDTH  = 8,
  parameter int NREQ    = 4,
  parameter int OPW     = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*DWIDTH-1:0]   req_a_i,
  input  logic [NREQ*DWIDTH-1:0]   req_b_i,
  input  logic [NREQ*OPW-1:0]      req_op_i,
  output logic [NREQ-1:0]          resp_valid_o,
  input  logic [NREQ-1:0]          resp_ready_i,
  output logic [2*DWIDTH-1:0]      resp_res_o,
  output logic                     resp_err_o,
  output logic                     alu_start_o,
  output logic [DWIDTH-1:0]        alu_a_o,
  output logic [DWIDTH-1:0]        alu_b_o,
  output logic [OPW-1:0]           alu_op_o,
  input  logic                     alu_done_i,
  input  logic [2*DWIDTH-1:0]      alu_res_i,
  output logic                     busy_o,
  output logic [$clog2(NREQ)-1:0]  grant_id_o
);

  // state | meaning
  // IDLE  | search for a request from rr_ptr upward, accept winner
  // ISSUE | one-cycle ALU start pulse
  // WAIT  | wait for ALU done (or watchdog expiry)
  // RESP  | hold one-hot response until granted requester is ready

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW:0] NREQ_C = (GW+1)'(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [GW-1:0]       r_rr_ptr, r_grant, w_win, w_ptr_next, w_idx;
  logic [GW:0]         w_sum;
  logic                w_found, w_accept, w_resp_ack, w_wait_exit, w_tmo;
  logic [NREQ-1:0]     w_ready, w_grant_oh, r_resp_valid;
  logic [DWIDTH-1:0]   w_a, w_b, r_a, r_b;
  logic [OPW-1:0]      w_op, r_op;
  logic [2*DWIDTH-1:0] r_res;
  logic                r_start, r_busy;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (GW+1)'(i);
      if (w_sum >= NREQ_C) w_sum = w_sum - NREQ_C;
      w_idx = w_sum[GW-1:0];
      if (!w_found && req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_ready    = '0;
    w_grant_oh = '0;
    w_a        = '0;
    w_b        = '0;
    w_op       = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ready[i]    = (w_win == GW'(i));
      w_grant_oh[i] = (r_grant == GW'(i));
      if (w_win == GW'(i)) begin
        w_a  = req_a_i[i*DWIDTH +: DWIDTH];
        w_b  = req_b_i[i*DWIDTH +: DWIDTH];
        w_op = req_op_i[i*OPW +: OPW];
      end
    end
  end

  // Ready is only offered in IDLE and never while reset is asserted.
  assign req_ready_o = (r_state == S_IDLE && w_found && !rst) ? w_ready : '0;
  assign w_accept    = |(req_valid_i & req_ready_o);
  assign w_resp_ack  = |(resp_ready_i & w_grant_oh);
  assign w_ptr_next  = (w_win == GW'(NREQ-1)) ? '0 : w_win + 1'b1;
  assign w_wait_exit = alu_done_i || w_tmo;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next = S_ISSUE;
      S_ISSUE:                  w_next = S_WAIT;
      S_WAIT:  if (w_wait_exit) w_next = S_RESP;
      S_RESP:  if (w_resp_ack)  w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_res        <= '0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_resp_valid <= '0;
    end else begin
      r_state      <= w_next;
      r_start      <= (w_next == S_ISSUE);
      r_busy       <= (w_next != S_IDLE);
      r_resp_valid <= (w_next == S_RESP) ? w_grant_oh : '0;
      if (w_accept) begin
        r_grant  <= w_win;
        r_rr_ptr <= w_ptr_next;
        r_a      <= w_a;
        r_b      <= w_b;
        r_op     <= w_op;
      end
      // Done wins over an expiry in the same cycle.
      if (r_state == S_WAIT) begin
        if (alu_done_i)  r_res <= alu_res_i;
        else if (w_tmo)  r_res <= '0;
      end
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] r_tcnt;
  logic          r_err;

  assign w_tmo = (r_state == S_WAIT) && (r_tcnt == TW'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state != S_WAIT) r_tcnt <= '0;
      else                   r_tcnt <= r_tcnt + 1'b1;
      if (r_state == S_WAIT) begin
        if (alu_done_i) r_err <= 1'b0;
        else if (w_tmo) r_err <= 1'b1;
      end
    end
  end

  assign resp_err_o = r_err;
`else
  assign w_tmo      = 1'b0;
  assign resp_err_o = 1'b0;
`endif

  assign resp_valid_o = r_resp_valid;
  assign resp_res_o   = r_res;
  assign alu_start_o  = r_start;
  assign alu_a_o      = r_a;
  assign alu_b_o      = r_b;
  assign alu_op_o     = r_op;
  assign busy_o       = r_busy;
  assign grant_id_o   = r_grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural multiply ALU model.
// Define ALU_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid_i = '0;
  logic [3:0]  req_ready_o;
  logic [31:0] req_a_i, req_b_i;
  logic [15:0] req_op_i;
  logic [3:0]  resp_valid_o;
  logic [3:0]  resp_ready_i = '0;
  logic [15:0] resp_res_o;
  logic        resp_err_o;
  logic        alu_start_o;
  logic [7:0]  alu_a_o, alu_b_o;
  logic [3:0]  alu_op_o;
  logic        alu_done_i;
  logic [15:0] alu_res_i;
  logic        busy_o;
  logic [1:0]  grant_id_o;

  logic [7:0]  a_arr [4];
  logic [7:0]  b_arr [4];
  logic [3:0]  op_arr[4];

  int          checks = 0;
  int          errors = 0;
  int          alu_delay = 0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_res = '0;
  logic        s_done = 1'b0;
  logic [15:0] s_res = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      req_a_i[k*8 +: 8]  = a_arr[k];
      req_b_i[k*8 +: 8]  = b_arr[k];
      req_op_i[k*4 +: 4] = op_arr[k];
    end
  end

  assign alu_done_i = m_done | s_done;
  assign alu_res_i  = m_done ? m_res : s_res;

  // ALU model: multiply, done alu_delay cycles after start; 0 means never.
  always begin
    @(posedge clk); #1;
    m_done = 1'b0;
    if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_res  = {8'h00, alu_a_o} * {8'h00, alu_b_o};
      end
    end
    if (alu_start_o && alu_delay != 0) m_cnt = alu_delay;
  end

  alu_arbiter #(.DWIDTH(8), .NREQ(4), .OPW(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_res_o(resp_res_o), .resp_err_o(resp_err_o),
    .alu_start_o(alu_start_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_op_o(alu_op_o), .alu_done_i(alu_done_i), .alu_res_i(alu_res_i),
    .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid_i = 4'b1111;
    tick(); tick();
    checks++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (alu_start_o !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", alu_start_o); end
    checks++; if (resp_valid_o !== 4'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0000", resp_valid_o); end
    checks++; if ({alu_a_o, alu_b_o, alu_op_o} !== 20'h0) begin errors++; $display("FAIL rst_operands: got %h want 00000", {alu_a_o, alu_b_o, alu_op_o}); end
    checks++; if ({resp_res_o, resp_err_o} !== 17'h0) begin errors++; $display("FAIL rst_result: got %h want 00000", {resp_res_o, resp_err_o}); end
    req_valid_i = 4'b0;
    rst = 1'b0;
    tick();
    checks++; if (grant_id_o !== 2'd0) begin errors++; $display("FAIL idle_grant: got %0d want 0", grant_id_o); end
    checks++; if ({busy_o, alu_start_o, resp_valid_o, req_ready_o} !== 10'h0) begin errors++; $display("FAIL idle_outputs: got %h want 000", {busy_o, alu_start_o, resp_valid_o, req_ready_o}); end
  endtask

  task automatic test_single();
    int n;
    a_arr[2] = 8'h0F; b_arr[2] = 8'h03; op_arr[2] = 4'h2;
    alu_delay = 3;
    resp_ready_i = 4'b1111;
    req_valid_i = 4'b0100;
    #1;
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready_o); end
    tick();
    req_valid_i = 4'b0;
    checks++; if (alu_start_o !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", alu_start_o); end
    checks++; if ({alu_a_o, alu_b_o, alu_op_o} !== 20'h0F032) begin errors++; $display("FAIL single_operands: got %h want 0f032", {alu_a_o, alu_b_o, alu_op_o}); end
    checks++; if (grant_id_o !== 2'd2 || busy_o !== 1'b1) begin errors++; $display("FAIL single_grant: got id %0d busy %b want id 2 busy 1", grant_id_o, busy_o); end
    n = 1;
    while (resp_valid_o == 4'b0 && n < 30) begin tick(); n++; end
    checks++; if (n !== 5) begin errors++; $display("FAIL single_latency: got %0d want 5", n); end
    checks++; if (resp_valid_o !== 4'b0100) begin errors++; $display("FAIL single_resp_valid: got %b want 0100", resp_valid_o); end
    checks++; if (resp_res_o !== 16'h002D || resp_err_o !== 1'b0) begin errors++; $display("FAIL single_result: got %h err %b want 002d err 0", resp_res_o, resp_err_o); end
    tick();
    checks++; if (busy_o !== 1'b0 || resp_valid_o !== 4'b0) begin errors++; $display("FAIL single_return_idle: got busy %b valid %b want 0 0000", busy_o, resp_valid_o); end
  endtask

  task automatic test_back_to_back();
    int gap;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin a_arr[k] = 8'h10 + 8'(k); b_arr[k] = 8'h01; op_arr[k] = 4'h2; end
    alu_delay = 1;
    resp_ready_i = 4'b1111;
    req_valid_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      gap = 0;
      do begin tick(); gap++; end while (!alu_start_o && gap < 12);
      if (g == 4) req_valid_i = 4'b0;
      checks++; if (gap !== ((g == 0) ? 1 : 4)) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", g, gap, (g == 0) ? 1 : 4); end
      checks++; if (grant_id_o !== 2'(g % 4)) begin errors++; $display("FAIL b2b_order[%0d]: got %0d want %0d", g, grant_id_o, g % 4); end
      checks++; if (alu_a_o !== 8'h10 + 8'(g % 4)) begin errors++; $display("FAIL b2b_operand[%0d]: got %h want %h", g, alu_a_o, 8'h10 + 8'(g % 4)); end
    end
    gap = 0;
    while (busy_o && gap < 12) begin tick(); gap++; end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy %b want 0", busy_o); end
  endtask

  task automatic test_backpressure();
    int n;
    a_arr[1] = 8'h11; b_arr[1] = 8'h05;
    alu_delay = 1;
    resp_ready_i = 4'b1101;
    req_valid_i = 4'b0010;
    tick();
    checks++; if (grant_id_o !== 2'd1) begin errors++; $display("FAIL bp_grant: got %0d want 1", grant_id_o); end
    req_valid_i = 4'b1001;
    n = 0;
    while (resp_valid_o == 4'b0 && n < 20) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      checks++; if (resp_valid_o !== 4'b0010) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 0010", c, resp_valid_o); end
      checks++; if (resp_res_o !== 16'h0055) begin errors++; $display("FAIL bp_result[%0d]: got %h want 0055", c, resp_res_o); end
      checks++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0000", c, req_ready_o); end
      tick();
    end
    req_valid_i = 4'b0;
    resp_ready_i = 4'b1111;
    tick();
    checks++; if (busy_o !== 1'b0 || resp_valid_o !== 4'b0) begin errors++; $display("FAIL bp_release: got busy %b valid %b want 0 0000", busy_o, resp_valid_o); end
  endtask

  task automatic test_stray_done();
    int n;
    a_arr[3] = 8'h21; b_arr[3] = 8'h02; op_arr[3] = 4'h2;
    alu_delay = 2;
    req_valid_i = 4'b1000;
    tick();
    req_valid_i = 4'b0;
    checks++; if (alu_start_o !== 1'b1 || grant_id_o !== 2'd3) begin errors++; $display("FAIL stray_issue: got start %b id %0d want 1 3", alu_start_o, grant_id_o); end
    s_res = 16'hBEEF; s_done = 1'b1;
    tick();
    s_done = 1'b0;
    n = 2;
    while (resp_valid_o == 4'b0 && n < 30) begin tick(); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL stray_latency: got %0d want 4", n); end
    checks++; if (resp_res_o !== 16'h0042 || resp_valid_o !== 4'b1000) begin errors++; $display("FAIL stray_result: got %h valid %b want 0042 1000", resp_res_o, resp_valid_o); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    a_arr[1] = 8'h07; b_arr[1] = 8'h07;
    alu_delay = 0;
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = 4'b0;
    tick();
    checks++; if (busy_o !== 1'b1 || alu_start_o !== 1'b0 || grant_id_o !== 2'd1) begin errors++; $display("FAIL rw_in_wait: got busy %b start %b id %0d want 1 0 1", busy_o, alu_start_o, grant_id_o); end
    rst = 1'b1;
    tick();
    checks++; if (busy_o !== 1'b0 || grant_id_o !== 2'd0 || alu_a_o !== 8'h00) begin errors++; $display("FAIL rw_reset: got busy %b id %0d a %h want 0 0 00", busy_o, grant_id_o, alu_a_o); end
    rst = 1'b0;
    tick();
    s_res = 16'h1234; s_done = 1'b1;
    tick();
    s_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (resp_valid_o !== 4'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rw_late_done[%0d]: got valid %b busy %b want 0000 0", c, resp_valid_o, busy_o); end
      tick();
    end
  endtask

`ifdef ALU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    a_arr[2] = 8'h03; b_arr[2] = 8'h04;
    alu_delay = 0;
    resp_ready_i = 4'b1111;
    req_valid_i = 4'b0100;
    tick();
    req_valid_i = 4'b0;
    n = 1;
    while (resp_valid_o == 4'b0 && n < 40) begin tick(); n++; end
    checks++; if (n !== 18) begin errors++; $display("FAIL tmo_latency: got %0d want 18", n); end
    checks++; if (resp_err_o !== 1'b1 || resp_res_o !== 16'h0 || resp_valid_o !== 4'b0100) begin errors++; $display("FAIL tmo_resp: got err %b res %h valid %b want 1 0000 0100", resp_err_o, resp_res_o, resp_valid_o); end
    tick();
    a_arr[2] = 8'h05; b_arr[2] = 8'h06;
    alu_delay = 1;
    req_valid_i = 4'b0100;
    tick();
    req_valid_i = 4'b0;
    n = 1;
    while (resp_valid_o == 4'b0 && n < 40) begin tick(); n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL tmo_next_latency: got %0d want 3", n); end
    checks++; if (resp_err_o !== 1'b0 || resp_res_o !== 16'h001E) begin errors++; $display("FAIL tmo_next_resp: got err %b res %h want 0 001e", resp_err_o, resp_res_o); end
    tick();
  endtask
`endif

  initial begin
    for (int k = 0; k < 4; k++) begin a_arr[k] = '0; b_arr[k] = '0; op_arr[k] = '0; end
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_stray_done();
    test_reset_in_wait();
`ifdef ALU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
